refund_dispenser: RTL and testbench

//  Dispensing end of the refund path. Consumes the post-release refund pulse
//  and returns the held credit as a timed train of coin-eject pulses:

---
 rtl/refund_dispenser.sv | 148 ++++++++++++++
 tb/tb_refund_dispenser.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/refund_dispenser.sv
// ============================================================================
//  Module   : refund_dispenser
//  Function : Returns latched refund credit as a greedy train of quarter,
//             dime and nickel eject pulses, then reports completion.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module refund_dispenser #(
    parameter int CREDIT_W   = 8,
    parameter int PULSE_TICS = 2,
    parameter int GAP_TICS   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                refund_req,
    input  logic [CREDIT_W-1:0] credit,
    output logic                clear_credit,
    output logic                coin_q,
    output logic                coin_d,
    output logic                coin_n,
    output logic                busy,
    output logic                done,
    output logic                residue
);

    localparam int TIC_MAX = (PULSE_TICS > GAP_TICS) ? PULSE_TICS : GAP_TICS;
    localparam int TIC_W   = $clog2(TIC_MAX) + 1;

    localparam logic [TIC_W-1:0]    C_PULSE_LAST = TIC_W'(PULSE_TICS - 1);
    localparam logic [TIC_W-1:0]    C_GAP_LAST   = TIC_W'(GAP_TICS - 1);
    localparam logic [CREDIT_W-1:0] C_VAL_Q      = CREDIT_W'(25);
    localparam logic [CREDIT_W-1:0] C_VAL_D      = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] C_VAL_N      = CREDIT_W'(5);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COIN_Q = 2'd0,
        COIN_D = 2'd1,
        COIN_N = 2'd2
    } coin_t;

    state_t              state_q,     state_d;
    coin_t               coin_sel_q,  coin_sel_d;
    logic [CREDIT_W-1:0] remaining_q, remaining_d;
    logic [TIC_W-1:0]    tic_q,       tic_d;
    logic                clear_q,     clear_d;

    // Only called with amt >= 5, so nickel is the safe fallback.
    function automatic coin_t pick_coin(input logic [CREDIT_W-1:0] amt);
        if (amt >= C_VAL_Q)      return COIN_Q;
        else if (amt >= C_VAL_D) return COIN_D;
        else                     return COIN_N;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input coin_t sel);
        unique case (sel)
            COIN_Q:  return C_VAL_Q;
            COIN_D:  return C_VAL_D;
            default: return C_VAL_N;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            coin_sel_q  <= COIN_Q;
            remaining_q <= '0;
            tic_q       <= '0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            coin_sel_q  <= coin_sel_d;
            remaining_q <= remaining_d;
            tic_q       <= tic_d;
            clear_q     <= clear_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        coin_sel_d  = coin_sel_q;
        remaining_d = remaining_q;
        tic_d       = tic_q;
        clear_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A zero-credit request is a no-op, which also absorbs the
                // second cycle of a two-cycle request once credit is cleared.
                if (refund_req && (credit != '0)) begin
                    remaining_d = credit;
                    clear_d     = 1'b1;
                    tic_d       = '0;
                    if (credit >= C_VAL_N) begin
                        coin_sel_d = pick_coin(credit);
                        state_d    = ST_PULSE;
                    end else begin
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_PULSE: begin
                if (tic_q == C_PULSE_LAST) begin
                    remaining_d = remaining_q - coin_value(coin_sel_q);
                    tic_d       = '0;
                    state_d     = ST_GAP;
                end else begin
                    tic_d = tic_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (tic_q == C_GAP_LAST) begin
                    tic_d = '0;
                    if (remaining_q >= C_VAL_N) begin
                        coin_sel_d = pick_coin(remaining_q);
                        state_d    = ST_PULSE;
                    end else begin
                        state_d    = ST_DONE;
                    end
                end else begin
                    tic_d = tic_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end
        endcase
    end

    assign clear_credit = clear_q;
    assign coin_q       = (state_q == ST_PULSE) && (coin_sel_q == COIN_Q);
    assign coin_d       = (state_q == ST_PULSE) && (coin_sel_q == COIN_D);
    assign coin_n       = (state_q == ST_PULSE) && (coin_sel_q == COIN_N);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign residue      = (state_q == ST_DONE) && (remaining_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_refund_dispenser.sv
// ============================================================================
//  Module   : tb_refund_dispenser
//  Function : Directed and randomized checks of refund_dispenser against a
//             cycle-indexed greedy-change model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_refund_dispenser;

    localparam int P = 2;
    localparam int G = 2;

    logic       clk;
    logic       reset;
    logic       refund_req;
    logic [7:0] credit;
    logic       clear_credit, coin_q, coin_d, coin_n, busy, done, residue;

    int total = 0;
    int bad   = 0;

    refund_dispenser #(.CREDIT_W(8), .PULSE_TICS(P), .GAP_TICS(G)) dut (
        .clk          (clk),
        .reset        (reset),
        .refund_req   (refund_req),
        .credit       (credit),
        .clear_credit (clear_credit),
        .coin_q       (coin_q),
        .coin_d       (coin_d),
        .coin_n       (coin_n),
        .busy         (busy),
        .done         (done),
        .residue      (residue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int done_cycle(input int c);
        int nq, nd, nn;
        nq = c / 25;
        nd = (c % 25) / 10;
        nn = ((c % 25) % 10) / 5;
        return 1 + (nq + nd + nn) * (P + G);
    endfunction

    // Expected {clear, q, d, n, busy, done, residue} in cycle k after the
    // latch edge, for an accepted request of c cents.
    function automatic logic [6:0] expect_at(input int k, input int c);
        logic [6:0] e;
        int nq, nd, rem, dc, j, ph;
        e = '0;
        if (c == 0) return e;
        nq  = c / 25;
        nd  = (c % 25) / 10;
        rem = c % 5;
        dc  = done_cycle(c);
        if (k == 1)            e[6] = 1'b1;
        if (k >= 1 && k <= dc) e[2] = 1'b1;
        if (k == dc) begin
            e[1] = 1'b1;
            e[0] = (rem != 0);
        end
        if (k >= 1 && k < dc) begin
            j  = (k - 1) / (P + G);
            ph = (k - 1) % (P + G);
            if (ph < P) begin
                if (j < nq)           e[5] = 1'b1;
                else if (j < nq + nd) e[4] = 1'b1;
                else                  e[3] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check_vec(input string tag, input int k, input logic [6:0] exp_v);
        logic [6:0] obs;
        obs = {clear_credit, coin_q, coin_d, coin_n, busy, done, residue};
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, k, obs, exp_v);
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_vec(tag, i, 7'b0);
            @(posedge clk); #1;
        end
    endtask

    // Called #1 after a rising edge. Requests c cents at the next edge,
    // optionally raises another request (extra_at) while busy, optionally
    // pulls reset mid-cycle at abort_at and leaves it asserted.
    task automatic run_seq(input string tag, input int c, input int extra_at,
                           input int extra_credit, input int abort_at);
        int last;
        refund_req = 1'b1;
        credit     = 8'(c);
        @(posedge clk); #1;
        refund_req = 1'b0;
        credit     = 8'($urandom_range(0, 255));
        last = (c == 0) ? 4 : done_cycle(c) + 2;
        for (int k = 1; k <= last; k++) begin
            check_vec(tag, k, expect_at(k, c));
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1 check_vec({tag, "_async_rst"}, k, 7'b0);
                refund_req = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (k == extra_at) begin
                refund_req = 1'b1;
                credit     = 8'(extra_credit);
            end else begin
                refund_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        refund_req = 1'b0;
    endtask

    initial begin
        int c, dc, ex;
        reset      = 1'b0;
        refund_req = 1'b0;
        credit     = '0;
        repeat (2) @(posedge clk);
        #1 check_vec("reset_state", 0, 7'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_seq("rst_mid_q", 40, 0, 0, 2);
        reset = 1'b1;
        check_idle("post_rst_idle", 3);

        run_seq("c40", 40, 0, 0, 0);
        run_seq("c0_two_cyc", 0, 1, 0, 0);
        run_seq("c7", 7, 0, 0, 0);
        run_seq("c3", 3, 1, 3, 0);
        run_seq("c255_extra", 255, 20, 99, 0);
        check_idle("c255_tail", 2);

        run_seq("c35_rst_d", 35, 0, 0, 5);
        reset = 1'b1;
        check_idle("c35_post_rst", 2);
        run_seq("c10_clean", 10, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
            if (c == 0) begin
                run_seq("rand_zero", 0, 1, 0, 0);
            end else begin
                dc = done_cycle(c);
                ex = $urandom_range(1, dc);
                run_seq("rand", c, ex, $urandom_range(1, 255), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
